mmio_uart_timer: RTL and testbench
==================================

Name: mmio_uart_timer

Overview:
Memory-mapped responder on the core's data-memory bus. It sits beside the data BRAM, selected by an address decode, and implements the slave side of the same byte-enabled, 1-cycle-read-latency protocol.
- Provides a free-running 64-bit timer with a compare interrupt.
- Provides a FIFO-buffered 8N1 UART transmitter.
- ReadData timing matches the BRAM, so the core's load path treats both identically.

Parameters:
FIFO_DEPTH, 8, TX FIFO entries; power of 2, minimum 2
DEFAULT_DIV, 434, reset value of BAUDDIV (50 MHz / 115200)

Ports:
sys_clk  input  1  core clock
sys_rst_n  input  1  asynchronous active-low reset
MemSel  input  1  address decode hit for this block
MemWrite_EN  input  4  byte write enables; bit i covers WriteData[8i+7:8i]
MemAddr  input  32  byte address; register select is MemAddr[4:2]
WriteData  input  32  store data
ReadData  output  32  load data, registered
uart_tx  output  1  serial out, idle high
timer_irq  output  1  timer interrupt, registered level

Behaviour:
- Reset (async, sys_rst_n=0):
  - ReadData=0, uart_tx=1, timer_irq=0.
  - mtime=0, mtimecmp=all ones, BAUDDIV=DEFAULT_DIV.
  - FIFO empty, OVF=0, TX FSM in IDLE.
- Write: when MemSel=1, each byte lane with MemWrite_EN[i]=1 updates the register in the same clock edge.
- Read:
  - ReadData is loaded every cycle with the register at MemAddr[4:2] if MemSel=1, else 0.
  - Data is therefore valid the cycle after the address is presented.
  - Reads have no side effects; the bus carries no read strobe.
- Register map (word offset : name : access):
  - 0x00 TXDATA : W. A write with MemWrite_EN[0]=1 pushes WriteData[7:0]. If the FIFO is full, the byte is dropped and OVF is set. Reads return 0.
  - 0x04 STATUS : R.
    - Bit 0: fifo_full. Bit 1: fifo_empty. Bit 2: tx_busy (FSM not IDLE). Bit 3: OVF (sticky). Bit 4: timer_irq.
    - Writing 1 to bit 3 with lane 0 enabled clears OVF.
    - If an overflow push and the OVF clear land in the same cycle, set wins.
  - 0x08 BAUDDIV : RW, bits 15:0; upper bits read 0. A value of 0 is treated as 1.
  - 0x0C MTIME_LO / 0x10 MTIME_HI : RW. Written lanes replace counter bytes. The counter increments every cycle it is not written. Lo carries into hi.
  - 0x14 MTIMECMP_LO / 0x18 MTIMECMP_HI : RW.
  - 0x1C : reads 0, writes ignored.
- Timer:
  - timer_irq <= (mtime >= mtimecmp), unsigned 64-bit compare, registered one cycle.
  - mtime wraps from all ones to 0.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)+1-bit pointers.
  - A simultaneous push and pop while full is legal: the pop frees the slot first, so the push succeeds and OVF is not set.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: when the FIFO is non-empty, pop into the shift register, load the bit counter to BAUDDIV-1, go to START.
  - Each non-IDLE state lasts BAUDDIV cycles:
    - START drives 0.
    - DATA drives 8 bits, LSB first.
    - STOP drives 1.
  - After STOP, if the FIFO is non-empty, the next frame's START begins directly (back-to-back, no idle gap). Otherwise go to IDLE.
  - BAUDDIV is sampled at each bit start; a mid-frame write affects the next bit only.
  - uart_tx is registered.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined: the FSM adds a PARITY state between DATA and STOP. It drives even parity (XOR of the 8 data bits) for BAUDDIV cycles, making an 11-bit frame.
- Undefined: 10-bit 8N1 frame, no PARITY state.

Test Plan:
- Reset mid-frame (BAUDDIV=4, byte 0x55 in flight), assert sys_rst_n=0 -> uart_tx=1, STATUS reads 0x02, BAUDDIV reads 434 after release.
- BAUDDIV=4, write 0xA5 to TXDATA -> uart_tx pattern 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total); tx_busy=1 throughout, then 0.
- Write 9 bytes back-to-back with BAUDDIV=100:
  - First byte pops immediately; 8 are queued; the 9th push succeeds.
  - 10th push -> OVF=1, STATUS bit 0=1.
  - Write 0x08 to STATUS -> OVF=0.
- mtimecmp=0x0000_0001_0000_0005, mtime written to 0x0000_0000_FFFF_FFFE -> carry into hi observed. timer_irq rises exactly 1 cycle after mtime reaches 0x1_0000_0005.
- Byte-lane write MemWrite_EN=4'b0100 of 0x00AB0000 to BAUDDIV (0x1B2) -> reads 0x01B2 (lane 2 lies above bits 15:0). Same write to MTIMECMP_LO (all ones) -> reads 0xFFABFFFF.
- Read address 0x0C with MemSel=1 at cycle n -> ReadData holds mtime sampled at edge n on cycle n+1. With MemSel=0 -> ReadData=0.

Source files
------------

// File: rtl/mmio_uart_timer.sv
// mmio_uart_timer: memory-mapped 64-bit timer with compare interrupt plus FIFO-buffered UART transmitter.
// Latency: writes land at the addressing edge; ReadData is registered, valid the cycle after the address.
// Backpressure: none on the bus; TXDATA pushes into a full FIFO are dropped and raise sticky OVF.
// Optional: define UART_PARITY_EN to insert an even-parity bit between DATA and STOP (11-bit frame).
module mmio_uart_timer #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DEFAULT_DIV = 434
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        MemSel,
  input  logic [3:0]  MemWrite_EN,
  input  logic [31:0] MemAddr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        uart_tx,
  output logic        timer_irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] A_TXDATA = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_BAUD   = 3'd2;
  localparam logic [2:0] A_MTLO   = 3'd3;
  localparam logic [2:0] A_MTHI   = 3'd4;
  localparam logic [2:0] A_CMPLO  = 3'd5;
  localparam logic [2:0] A_CMPHI  = 3'd6;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} tx_state_e;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  logic [3:0]  wr_be;
  logic [2:0]  reg_sel;
  logic        unused_addr;

  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [15:0] baud_q, baud_d, div_m1;
  logic        ovf_q, ovf_d, irq_q;
  logic [31:0] rdata_q, rdata_d;

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        fifo_full, fifo_empty, push_req, push, pop;
  logic [7:0]  fifo_head;

  tx_state_e   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        tx_q, tx_d;
`ifdef UART_PARITY_EN
  logic        par_q, par_d;
`endif

  assign wr_be       = MemSel ? MemWrite_EN : 4'b0000;
  assign reg_sel     = MemAddr[4:2];
  assign unused_addr = ^{MemAddr[31:5], MemAddr[1:0]};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign fifo_head  = fifo_mem[rptr_q[AW-1:0]];
  assign push_req   = wr_be[0] && (reg_sel == A_TXDATA);
  // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
  assign push       = push_req && (!fifo_full || pop);

  // A BAUDDIV of 0 behaves as 1; the bit counter counts down from divisor-1.
  assign div_m1 = (baud_q == 16'd0) ? 16'd0 : baud_q - 16'd1;

  // Register-file next state: byte-lane writes, free-running timer, sticky overflow.
  always_comb begin
    baud_d     = baud_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = mtime_q + 64'd1;
    ovf_d      = ovf_q;
    if (|wr_be) begin
      case (reg_sel)
        A_BAUD: begin
          if (wr_be[0]) baud_d[7:0]  = WriteData[7:0];
          if (wr_be[1]) baud_d[15:8] = WriteData[15:8];
        end
        A_MTLO:  mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], WriteData, wr_be)};
        A_MTHI:  mtime_d = {merge_bytes(mtime_q[63:32], WriteData, wr_be), mtime_q[31:0]};
        A_CMPLO: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], WriteData, wr_be);
        A_CMPHI: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], WriteData, wr_be);
        default: ;
      endcase
    end
    if (wr_be[0] && (reg_sel == A_STATUS) && WriteData[3]) ovf_d = 1'b0;
    // Overflow set takes priority over a same-cycle clear.
    if (push_req && !push) ovf_d = 1'b1;
  end

  // Read mux: returns 0 when not selected so the core can OR this with BRAM data.
  always_comb begin
    rdata_d = 32'h0;
    if (MemSel) begin
      case (reg_sel)
        A_STATUS: rdata_d = {27'h0, irq_q, ovf_q, (state_q != S_IDLE), fifo_empty, fifo_full};
        A_BAUD:   rdata_d = {16'h0, baud_q};
        A_MTLO:   rdata_d = mtime_q[31:0];
        A_MTHI:   rdata_d = mtime_q[63:32];
        A_CMPLO:  rdata_d = mtimecmp_q[31:0];
        A_CMPHI:  rdata_d = mtimecmp_q[63:32];
        default:  rdata_d = 32'h0;
      endcase
    end
  end

  // TX FSM: each non-idle state holds for one divisor period; STOP chains straight into the next START.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pop     = 1'b0;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != S_IDLE) cnt_d = cnt_q - 16'd1;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_START;
          cnt_d   = div_m1;
          shift_d = fifo_head;
`ifdef UART_PARITY_EN
          par_d   = ^fifo_head;
`endif
        end
      end
      S_START: begin
        if (cnt_q == 16'd0) begin
          state_d = S_DATA;
          cnt_d   = div_m1;
          idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = div_m1;
          idx_d   = idx_q + 3'd1;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (cnt_q == 16'd0) begin
          state_d = S_STOP;
          cnt_d   = div_m1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == 16'd0) begin
          cnt_d = div_m1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_START;
            shift_d = fifo_head;
`ifdef UART_PARITY_EN
            par_d   = ^fifo_head;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the state being entered so uart_tx lines up with the state register.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
`ifdef UART_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge sys_clk) begin
    if (push) fifo_mem[wptr_q[AW-1:0]] <= WriteData[7:0];
  end

  // State registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mtime_q    <= 64'h0;
      mtimecmp_q <= {64{1'b1}};
      baud_q     <= 16'(DEFAULT_DIV);
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
      rdata_q    <= 32'h0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      state_q    <= S_IDLE;
      shift_q    <= 8'h0;
      cnt_q      <= 16'h0;
      idx_q      <= 3'd0;
      tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      baud_q     <= baud_d;
      ovf_q      <= ovf_d;
      irq_q      <= (mtime_q >= mtimecmp_q);
      rdata_q    <= rdata_d;
      wptr_q     <= wptr_q + (AW+1)'(push);
      rptr_q     <= rptr_q + (AW+1)'(pop);
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      tx_q       <= tx_d;
`ifdef UART_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign ReadData  = rdata_q;
  assign uart_tx   = tx_q;
  assign timer_irq = irq_q;

endmodule

// File: tb/tb_mmio_uart_timer.sv
// Bench for mmio_uart_timer: queue/bit-list reference model compared every cycle, plus literal scenario checks.
`timescale 1ns/1ps
module tb_mmio_uart_timer;
  localparam int DEPTH   = 8;
  localparam int DEF_DIV = 434;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemSel = 1'b0;
  logic [3:0]  MemWrite_EN = 4'h0;
  logic [31:0] MemAddr = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData;
  logic        uart_tx;
  logic        timer_irq;

  mmio_uart_timer #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DEF_DIV)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .MemSel(MemSel), .MemWrite_EN(MemWrite_EN),
    .MemAddr(MemAddr), .WriteData(WriteData), .ReadData(ReadData),
    .uart_tx(uart_tx), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  byte unsigned     m_q[$];
  logic [63:0]      m_time, m_cmp;
  logic [15:0]      m_baud;
  bit               m_ovf, m_irq, m_busy;
  logic [31:0]      m_rd;
  logic [NB-1:0]    m_bits;
  int               m_bit, m_rem;

  function automatic int eff_div(input logic [15:0] b);
    return (b == 16'd0) ? 1 : int'(b);
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (wd & m);
  endfunction

  function automatic logic exp_tx();
    return m_busy ? m_bits[m_bit] : 1'b1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_time = 64'h0; m_cmp = '1; m_baud = 16'(DEF_DIV);
    m_ovf = 0; m_irq = 0; m_busy = 0; m_rd = 32'h0;
    m_bits = '1; m_bit = 0; m_rem = 0;
  endtask

  // A frame is the list of line levels: start 0, eight data bits LSB first, optional parity, stop 1.
  task automatic start_frame();
    logic [7:0] d;
    d = m_q.pop_front();
    m_bits = '1;
    m_bits[0] = 1'b0;
    m_bits[8:1] = d;
`ifdef UART_PARITY_EN
    m_bits[9] = ^d;
`endif
    m_bit = 0; m_rem = eff_div(m_baud); m_busy = 1;
  endtask

  task automatic model_step();
    logic [2:0]  w;
    logic [3:0]  be;
    logic [31:0] tmp;
    logic [63:0] t;
    bit          f_empty, f_full, ovf_set, irq_n;
    w  = MemAddr[4:2];
    be = MemSel ? MemWrite_EN : 4'h0;
    f_empty = (m_q.size() == 0);
    f_full  = (m_q.size() == DEPTH);
    m_rd = 32'h0;
    if (MemSel) begin
      case (w)
        3'd1: m_rd = {27'd0, m_irq, m_ovf, m_busy, f_empty, f_full};
        3'd2: m_rd = {16'd0, m_baud};
        3'd3: m_rd = m_time[31:0];
        3'd4: m_rd = m_time[63:32];
        3'd5: m_rd = m_cmp[31:0];
        3'd6: m_rd = m_cmp[63:32];
        default: m_rd = 32'h0;
      endcase
    end
    irq_n = (m_time >= m_cmp);
    // transmitter
    if (!m_busy) begin
      if (m_q.size() != 0) start_frame();
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_bit++;
        if (m_bit == NB) begin
          m_busy = 0;
          if (m_q.size() != 0) start_frame();
        end else begin
          m_rem = eff_div(m_baud);
        end
      end
    end
    // FIFO push happens after this edge's pop
    ovf_set = 0;
    if (be[0] && w == 3'd0) begin
      if (m_q.size() < DEPTH) m_q.push_back(WriteData[7:0]);
      else ovf_set = 1;
    end
    if (be[0] && w == 3'd1 && WriteData[3]) m_ovf = 0;
    if (ovf_set) m_ovf = 1;
    // registers
    t = m_time + 64'd1;
    if (|be) begin
      case (w)
        3'd2: begin tmp = lanes({16'd0, m_baud}, WriteData, {2'b00, be[1:0]}); m_baud = tmp[15:0]; end
        3'd3: t = {m_time[63:32], lanes(m_time[31:0], WriteData, be)};
        3'd4: t = {lanes(m_time[63:32], WriteData, be), m_time[31:0]};
        3'd5: m_cmp[31:0]  = lanes(m_cmp[31:0], WriteData, be);
        3'd6: m_cmp[63:32] = lanes(m_cmp[63:32], WriteData, be);
        default: ;
      endcase
    end
    m_time = t;
    m_irq  = irq_n;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("cyc_ReadData", {32'h0, ReadData}, {32'h0, m_rd});
    chk("cyc_uart_tx", {63'h0, uart_tx}, {63'h0, exp_tx()});
    chk("cyc_timer_irq", {63'h0, timer_irq}, {63'h0, m_irq});
  end

  // ---------------- bus helpers ----------------
  task automatic cyc(input logic sel, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    MemSel = sel; MemWrite_EN = be; MemAddr = a; WriteData = d;
    @(posedge clk); #1;
    MemSel = 1'b0; MemWrite_EN = 4'h0; MemAddr = 32'h0; WriteData = 32'h0;
  endtask

  task automatic wr_reg(input logic [2:0] w, input logic [3:0] be, input logic [31:0] d);
    cyc(1'b1, be, {27'd0, w, 2'b00}, d);
  endtask

  task automatic rd_reg(input logic [2:0] w, output logic [31:0] rd);
    cyc(1'b1, 4'h0, {27'd0, w, 2'b00}, 32'h0);
    rd = ReadData;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]   rd, v0, v1;
    logic [NB-1:0] pat;
    int            bad_bits, bad_busy, guard;
    bit            drained;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ReadData", {32'h0, ReadData}, 64'h0);
    chk("reset_uart_tx", {63'h0, uart_tx}, 64'h1);
    chk("reset_irq", {63'h0, timer_irq}, 64'h0);
    rst_n = 1'b1;
    rd_reg(3'd2, rd); chk("reset_bauddiv", {32'h0, rd}, 64'd434);
    rd_reg(3'd1, rd); chk("reset_status", {32'h0, rd}, 64'h2);

    // Single frame 0xA5 at divisor 4
`ifdef UART_PARITY_EN
    pat = 11'b10101001010;
`else
    pat = 10'b1101001010;
`endif
    wr_reg(3'd2, 4'b0011, 32'd4);
    wr_reg(3'd0, 4'b0001, 32'hA5);
    bad_bits = 0; bad_busy = 0;
    for (int i = 0; i < NB*4; i++) begin
      rd_reg(3'd1, rd);
      if (uart_tx !== pat[i/4]) bad_bits++;
      if (i >= 1 && rd[2] !== 1'b1) bad_busy++;
    end
    chk("a5_frame_bits", 64'(bad_bits), 64'h0);
    chk("a5_busy_during_frame", 64'(bad_busy), 64'h0);
    rd_reg(3'd1, rd);
    chk("a5_busy_last_stop", {63'h0, rd[2]}, 64'h1);
    chk("a5_line_idle", {63'h0, uart_tx}, 64'h1);
    rd_reg(3'd1, rd); chk("a5_status_idle", {32'h0, rd}, 64'h2);

    // Reset while 0x55 is on the line
    wr_reg(3'd0, 4'b0001, 32'h55);
    idle(2);
    chk("midframe_line_low", {63'h0, uart_tx}, 64'h0);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_tx", {63'h0, uart_tx}, 64'h1);
    chk("midframe_reset_rd", {32'h0, ReadData}, 64'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    rd_reg(3'd1, rd); chk("midframe_status", {32'h0, rd}, 64'h2);
    rd_reg(3'd2, rd); chk("midframe_bauddiv", {32'h0, rd}, 64'd434);

    // Fill FIFO, overflow, clear
    wr_reg(3'd2, 4'b0011, 32'd100);
    for (int k = 0; k < 9; k++) wr_reg(3'd0, 4'b0001, 32'h30 + 32'(k));
    rd_reg(3'd1, rd); chk("status_after_9_pushes", {32'h0, rd}, 64'h5);
    wr_reg(3'd0, 4'b0001, 32'h39);
    rd_reg(3'd1, rd); chk("status_overflow", {32'h0, rd}, 64'hD);
    wr_reg(3'd1, 4'b0001, 32'h08);
    rd_reg(3'd1, rd); chk("status_ovf_cleared", {32'h0, rd}, 64'h5);
    wr_reg(3'd2, 4'b0011, 32'd1);
    drained = 0;
    guard = 0;
    while (!drained && guard < 3000) begin
      rd_reg(3'd1, rd);
      if (rd[2:1] == 2'b01) drained = 1;
      guard++;
    end
    chk("drain_within_bound", {63'h0, drained}, 64'h1);

    // Timer carry and compare
    wr_reg(3'd6, 4'hF, 32'h1);
    wr_reg(3'd5, 4'hF, 32'h5);
    wr_reg(3'd4, 4'hF, 32'h0);
    wr_reg(3'd3, 4'hF, 32'hFFFF_FFFE);
    rd_reg(3'd3, rd); chk("mtime_lo_written", {32'h0, rd}, 64'hFFFF_FFFE);
    rd_reg(3'd4, rd); chk("mtime_hi_before_carry", {32'h0, rd}, 64'h0);
    rd_reg(3'd4, rd); chk("mtime_hi_after_carry", {32'h0, rd}, 64'h1);
    idle(4);
    chk("irq_not_yet", {63'h0, timer_irq}, 64'h0);
    idle(1);
    chk("irq_rises", {63'h0, timer_irq}, 64'h1);

    // Read path
    cyc(1'b0, 4'h0, 32'h0000_000C, 32'h0);
    chk("memsel0_reads_zero", {32'h0, ReadData}, 64'h0);
    rd_reg(3'd3, v0);
    rd_reg(3'd3, v1);
    chk("mtime_consecutive_reads", {32'h0, v1 - v0}, 64'h1);

    // Byte lanes
    wr_reg(3'd2, 4'b0011, 32'h1B2);
    wr_reg(3'd2, 4'b0100, 32'h00AB_0000);
    rd_reg(3'd2, rd); chk("bauddiv_lane2_ignored", {32'h0, rd}, 64'h1B2);
    wr_reg(3'd5, 4'hF, 32'hFFFF_FFFF);
    wr_reg(3'd5, 4'b0100, 32'h00AB_0000);
    rd_reg(3'd5, rd); chk("mtimecmp_lo_lane2", {32'h0, rd}, 64'hFFAB_FFFF);
    rd_reg(3'd7, rd); chk("reserved_reads_zero", {32'h0, rd}, 64'h0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] a, d;
      logic [3:0]  be;
      logic [2:0]  w;
      logic        sel;
      a   = $urandom();
      w   = 3'($urandom_range(0, 7));
      a[4:2] = w;
      be  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) be = 4'h0;
      d   = $urandom();
      if (w == 3'd2) d = 32'($urandom_range(0, 5));
      if (w >= 3'd3 && w <= 3'd6 && $urandom_range(0, 7) != 0) be = 4'h0;
      sel = ($urandom_range(0, 9) != 0);
      cyc(sel, be, a, d);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
